// File: rtl/dg0045_cycle_sequencer.sv
// dg0045_cycle_sequencer
// Machine-cycle sequencer for the DG0045 4-bit core. It splits clk_in into
// 8-clock machine cycles and decodes the F1/F2 phase strobes, the ROM
// address-mux select and the fetch strobe. Run/halt/single-step control and
// a PC breakpoint let the core stop only on machine-cycle boundaries.
module dg0045_cycle_sequencer #(
  parameter bit HALT_AT_RESET = 1'b0,
  parameter int CNT_W         = 16
) (
  input  logic             clk_in,
  input  logic             RESET,
  input  logic             ena,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             bkpt_en,
  input  logic [9:0]       bkpt_addr,
  input  logic [9:0]       pc,
  output logic [2:0]       phase,
  output logic             F1,
  output logic             F2,
  output logic             rom_mux,
  output logic             fetch_strobe,
  output logic             halted,
  output logic             bkpt_hit,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       phase_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             bkpt_hit_reg;
  logic             guard_reg;      // masks the breakpoint for one boundary after a resume
  logic             halt_pend_reg;  // halt_req seen earlier in the current RUN cycle

  logic boundary;
  logic bkpt_term;
  logic stop;
  logic leaving_halt;

  // The phase counter only advances outside HALTED, so a boundary is phase 7 there.
  assign boundary     = (state_reg != ST_HALTED) && (phase_reg == 3'd7);
  // pc only matters on the boundary clock (phase 7), when the core holds it stable.
  assign bkpt_term    = bkpt_en && (pc == bkpt_addr) && !guard_reg;
  // A halt request pulsed mid-cycle is remembered so the cycle still finishes first.
  assign stop         = halt_req || halt_pend_reg || bkpt_term;
  assign leaving_halt = (state_reg == ST_HALTED) && (state_next != ST_HALTED);

  // State register: async active-low reset, frozen while ena is low.
  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      state_reg <= ST_WARMUP;
    end else if (ena) begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: transitions happen only on boundaries, except leaving HALTED.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_WARMUP: if (boundary) state_next = HALT_AT_RESET ? ST_HALTED : ST_RUN;
      ST_RUN:    if (boundary && stop) state_next = ST_HALTED;
      ST_HALTED: begin
        // halt_req has priority over both resume requests.
        if (!halt_req) begin
          if (run_req)       state_next = ST_RUN;
          else if (step_req) state_next = ST_STEP;
        end
      end
      ST_STEP:   if (boundary) state_next = ST_HALTED;
      default:   state_next = ST_WARMUP;
    endcase
  end

  // Phase counter, cycle counter and the breakpoint/halt bookkeeping flags.
  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      phase_reg     <= 3'd0;
      cnt_reg       <= '0;
      bkpt_hit_reg  <= 1'b0;
      guard_reg     <= 1'b0;
      halt_pend_reg <= 1'b0;
    end else if (ena) begin
      // Wrapping 7 -> 0 also leaves phase at 0 when entering HALTED.
      if (state_reg == ST_HALTED) phase_reg <= 3'd0;
      else                        phase_reg <= phase_reg + 3'd1;

      if (boundary && (state_reg != ST_WARMUP))
        cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};

      if (state_reg != ST_RUN || boundary) halt_pend_reg <= 1'b0;
      else if (halt_req)                   halt_pend_reg <= 1'b1;

      if (leaving_halt)  guard_reg <= 1'b1;
      else if (boundary) guard_reg <= 1'b0;

      // Sticky hit; only a run resume clears it, a single step leaves it alone.
      if (state_reg == ST_RUN && boundary && bkpt_term)
        bkpt_hit_reg <= 1'b1;
      else if (leaving_halt && state_next == ST_RUN)
        bkpt_hit_reg <= 1'b0;
    end
  end

  // Output decode from registers only, strobes gated off in WARMUP and HALTED.
  always_comb begin
    phase        = phase_reg;
    rom_mux      = phase_reg[2];
    F1           = 1'b0;
    F2           = 1'b0;
    fetch_strobe = 1'b0;
    halted       = (state_reg == ST_HALTED);
    bkpt_hit     = bkpt_hit_reg;
    cycle_cnt    = cnt_reg;
    if (state_reg == ST_RUN || state_reg == ST_STEP) begin
      F1           = (phase_reg[2:1] == 2'b01);
      F2           = (phase_reg[2:1] == 2'b11);
      fetch_strobe = (phase_reg == 3'd3);
    end
  end

endmodule

// File: doc/dg0045_cycle_sequencer.md
Name: dg0045_cycle_sequencer

Overview:
Machine-cycle sequencer for the DG0045 4-bit core.
- Divides clk_in into 8-clock machine cycles and generates the F1/F2 phase strobes, the ROM address-mux select and the instruction fetch strobe.
- Adds run/halt/single-step control and a 10-bit PC breakpoint.
- Sits between the top-level clock/enable pins and the core, replacing the free-running divider so the core can be stopped on machine-cycle boundaries.

Parameters:
HALT_AT_RESET, 0, 1 = enter HALTED after warm-up cycle instead of RUN
CNT_W, 16, width of completed-cycle counter

Ports:
clk_in  input  1  sequencer clock, rising edge
RESET  input  1  asynchronous reset, active-low
ena  input  1  clock enable; 0 freezes all state and outputs
run_req  input  1  level; leave HALTED, clear bkpt_hit
halt_req  input  1  level; stop at next cycle boundary
step_req  input  1  one-clk pulse; execute one machine cycle from HALTED
bkpt_en  input  1  breakpoint enable
bkpt_addr  input  10  breakpoint PC {PU,PL}
pc  input  10  current core PC {PU,PL}
phase  output  3  phase within machine cycle, 0..7
F1  output  1  high in phases 2,3 (gated)
F2  output  1  high in phases 6,7 (gated)
rom_mux  output  1  0 in phases 0-3 (PL[4:0] out), 1 in phases 4-7 ({PU,PL[5]} out)
fetch_strobe  output  1  one clk pulse in phase 3 (ROM byte valid for F1 falling edge)
halted  output  1  1 in HALTED state
bkpt_hit  output  1  sticky; set when halt caused by breakpoint
cycle_cnt  output  CNT_W  completed machine cycles, wraps

Behaviour:
- Reset values: phase=0, F1=F2=0, rom_mux=0, fetch_strobe=0, halted=0, bkpt_hit=0, cycle_cnt=0, state=WARMUP.
- All state changes on rising clk_in when ena=1. With ena=0 nothing changes, including the counter, state and outputs.
- phase increments mod 8 in WARMUP, RUN and STEP. Boundary = clock where phase 7 -> 0. cycle_cnt increments at each boundary, except boundaries completing WARMUP.
- F1/F2/fetch_strobe are decoded from phase registers only (glitch-free) and forced 0 in WARMUP and HALTED.
- States:
  - WARMUP: one full cycle with strobes suppressed. At the boundary, go to HALTED if HALT_AT_RESET=1, else RUN.
  - RUN: at each boundary, evaluate stop = halt_req | (bkpt_en & pc==bkpt_addr & !resume_guard). If stop, go to HALTED and phase stays 0. Set bkpt_hit if the breakpoint term is true, including when halt_req is also true.
  - HALTED: phase held 0, halted=1.
    - halt_req=1 blocks leaving; halt_req wins over run_req.
    - Else run_req=1 -> RUN next clk, bkpt_hit cleared, resume_guard set.
    - Else step_req=1 -> STEP next clk, resume_guard set.
  - STEP: runs exactly one machine cycle, then HALTED at the boundary. The breakpoint check is masked. bkpt_hit is unchanged.
- resume_guard: masks the breakpoint compare at the first boundary after leaving HALTED, so execution can resume from the breakpoint address. It clears at that boundary.
- pc is sampled only at phase 7. It is stable, since the core updates PC at F1 rising / F2.
- step_req and run_req are ignored outside HALTED. step_req during WARMUP is lost.
- RESET asserted mid-cycle: immediate return to reset values. No partial strobe may remain high.

Test Plan:
1. Reset with HALT_AT_RESET=0, ena=1, 24 clocks -> F1/F2 stay 0 for clocks 0-7. Then F1=1 at phases 2,3 and F2=1 at phases 6,7, fetch_strobe one pulse per cycle at phase 3, rom_mux toggles at phase 4. cycle_cnt=2 after 24 clocks.
2. RUN, pulse halt_req at phase 3 -> cycle completes (F2 pulses), halted=1 at next clock, phase=0, bkpt_hit=0, strobes 0 for 20 clocks.
3. bkpt_en=1, bkpt_addr=10'h3C5, pc driven to 10'h3C5 in cycle N -> HALTED after boundary N, bkpt_hit=1. run_req with pc still 10'h3C5 -> one full cycle runs without re-halting, bkpt_hit cleared.
4. HALTED, step_req pulse -> exactly 8 clocks of phases 0..7 with one F1 and one F2 pair, then halted=1, cycle_cnt +1. Two step pulses give +2.
5. halt_req=1 and run_req=1 together in HALTED -> remains HALTED. ena=0 for 5 clocks mid-RUN at phase 5 -> phase stays 5, outputs frozen, resumes at 6.
6. RESET low at phase 6 (F2=1) -> F2 drops asynchronously, all outputs return to reset values, WARMUP repeats before the first F1.
